// File: rtl/multireceive_if.sv
// Bundle for the multi-digit symbol link (strobe + 3 data bits + enable)
// and the decoded-result bus presented to the keylock compare logic.
interface multireceive_if;
  logic        enabled;
  logic        in0;
  logic        in1;
  logic        in2;
  logic        controlIn;
  logic [31:0] num;
  logic        done;
  logic        busy;
  logic [2:0]  symCount;
  logic        error;

  modport master (
    output enabled, in0, in1, in2, controlIn,
    input  num, done, busy, symCount, error
  );

  modport slave (
    input  enabled, in0, in1, in2, controlIn,
    output num, done, busy, symCount, error
  );
endinterface

// File: rtl/multireceive.sv
// Multi-digit symbol receiver: glitch-filters the strobe, accumulates decimal digits MSD first.
// Optional inter-symbol timeout is compiled in with `define MULTIRECEIVE_TIMEOUT_EN.
module multireceive #(
  parameter int MIN_HIGH    = 1000,
  parameter int NUM_SYMBOLS = 6,
  parameter int TIMEOUT     = 3600000
) (
  input logic           hwclk,
  input logic           reset,
  multireceive_if.slave bus
);

  localparam int HW = $clog2(MIN_HIGH + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HIGH = 3'd1,
    S_FILTER    = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_COMPLETE  = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic          ctl_s;
  logic [2:0]    sym_s;
  logic [19:0]   acc_q, acc_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [31:0]   num_q, num_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          hit_s;
  logic          accept_s;
  logic          timeout_s;

  // Two-flop synchronizer on the strobe and data bits, all sharing the same delay.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
    end else begin
      sync1_q <= {bus.controlIn, bus.in2, bus.in1, bus.in0};
      sync2_q <= sync1_q;
    end
  end

  assign ctl_s    = sync2_q[3];
  assign sym_s    = sync2_q[2:0];
  assign hit_s    = (hcnt_q == HW'(MIN_HIGH));
  assign accept_s = (state_q == S_FILTER) && ctl_s && hit_s;

`ifdef MULTIRECEIVE_TIMEOUT_EN
  logic [31:0] gap_q, gap_d;

  assign timeout_s = (gap_q > 32'(TIMEOUT));

  // Gap counter: idle time between symbols of a started frame, restarted on any state change.
  always_comb begin
    gap_d = 32'd0;
    if (state_d != state_q) begin
      gap_d = 32'd0;
    end else if (((state_q == S_WAIT_HIGH) && (cnt_q != 3'd0)) || (state_q == S_WAIT_LOW)) begin
      gap_d = gap_q + 32'd1;
    end else begin
      gap_d = 32'd0;
    end
  end

  // Gap counter register.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      gap_q <= 32'd0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a low enable overrides every transition.
  always_comb begin
    state_d = state_q;
    if (!bus.enabled) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_HIGH;
        S_WAIT_HIGH: begin
          if (timeout_s) begin
            state_d = S_ERROR;
          end else if (ctl_s) begin
            state_d = S_FILTER;
          end else begin
            state_d = S_WAIT_HIGH;
          end
        end
        S_FILTER: begin
          if (!ctl_s) begin
            state_d = S_WAIT_HIGH;
          end else if (hit_s) begin
            state_d = S_WAIT_LOW;
          end else begin
            state_d = S_FILTER;
          end
        end
        S_WAIT_LOW: begin
          if (timeout_s) begin
            state_d = S_ERROR;
          end else if (!ctl_s) begin
            state_d = (cnt_q == 3'(NUM_SYMBOLS)) ? S_COMPLETE : S_WAIT_HIGH;
          end else begin
            state_d = S_WAIT_LOW;
          end
        end
        S_COMPLETE: state_d = S_COMPLETE;
        S_ERROR:    state_d = S_ERROR;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath next values (accumulator, counters, result bus).
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    num_d  = num_q;
    if (!bus.enabled) begin
      acc_d  = 20'd0;
      cnt_d  = 3'd0;
      hcnt_d = '0;
    end else begin
      if ((state_q == S_WAIT_HIGH) && ctl_s) begin
        hcnt_d = HW'(1);
      end else if ((state_q == S_FILTER) && ctl_s && !hit_s) begin
        hcnt_d = hcnt_q + HW'(1);
      end else begin
        hcnt_d = '0;
      end
      // acc*10 as shift-add; digits 0..7 go in unchecked.
      if (accept_s) begin
        acc_d = (acc_q << 3) + (acc_q << 1) + {17'd0, sym_s};
        cnt_d = cnt_q + 3'd1;
      end else begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
      if (state_q == S_COMPLETE) begin
        num_d = {12'd0, acc_q};
      end else begin
        num_d = num_q;
      end
    end
    done_d = bus.enabled && (state_q == S_COMPLETE);
    busy_d = (cnt_d != 3'd0) && (state_d != S_COMPLETE) && (state_d != S_ERROR);
`ifdef MULTIRECEIVE_TIMEOUT_EN
    error_d = (state_d == S_ERROR);
`else
    error_d = 1'b0;
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      acc_q   <= 20'd0;
      cnt_q   <= 3'd0;
      hcnt_q  <= '0;
      num_q   <= 32'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      num_q   <= num_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign bus.num      = num_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.symCount = cnt_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_multireceive.sv
// Randomized self-checking bench for multireceive; expected values come from decimal digit arithmetic.
module tb_multireceive;

  localparam int MIN_HIGH    = 8;
  localparam int NUM_SYMBOLS = 6;
  localparam int TIMEOUT     = 300;

  logic hwclk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   dig[NUM_SYMBOLS];
  int   last_num = 0;

  multireceive_if bus ();

  multireceive #(
    .MIN_HIGH   (MIN_HIGH),
    .NUM_SYMBOLS(NUM_SYMBOLS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .hwclk(hwclk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 hwclk = ~hwclk;

  function automatic int ref_value();
    int v = 0;
    for (int i = 0; i < NUM_SYMBOLS; i++) v += dig[i] * (10 ** (NUM_SYMBOLS - 1 - i));
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic send_sym(input int d, input int high);
    logic [2:0] dv;
    dv = 3'(d);
    bus.in0 = dv[0];
    bus.in1 = dv[1];
    bus.in2 = dv[2];
    bus.controlIn = 1'b1;
    tick(high);
    bus.controlIn = 1'b0;
  endtask

  task automatic rearm();
    bus.enabled = 1'b0;
    tick(1);
    bus.enabled = 1'b1;
    tick(2);
  endtask

  // Sends digits [0, upto) from dig[], with a gap after each, checking the running count.
  task automatic send_partial(input int upto, input string tag);
    for (int i = 0; i < upto; i++) begin
      send_sym(dig[i], MIN_HIGH + 2 + int'($urandom_range(10, 0)));
      tick(4 + int'($urandom_range(10, 0)));
      n_cmp++;
      if (bus.symCount !== 3'(i + 1) || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s_count: symCount=%0d busy=%b, required %0d/1", tag, bus.symCount, bus.busy, i + 1);
      end
    end
  endtask

  // Sends the whole dig[] frame and checks done latency and result.
  task automatic send_full(input string tag);
    int v;
    v = ref_value();
    send_partial(NUM_SYMBOLS - 1, tag);
    send_sym(dig[NUM_SYMBOLS-1], MIN_HIGH + 2 + int'($urandom_range(10, 0)));
    tick(3);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL %s_early_done: done=%b, required 0 three cycles after last fall", tag, bus.done);
    end
    tick(1);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.num !== 32'(v) || bus.symCount !== 3'(NUM_SYMBOLS)
        || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      n_err++;
      $display("FAIL %s_result: done=%b num=%0d symCount=%0d busy=%b error=%b, required 1/%0d/%0d/0/0",
               tag, bus.done, bus.num, bus.symCount, bus.busy, bus.error, v, NUM_SYMBOLS);
    end
    last_num = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_cmp++;
    if (bus.num !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.symCount !== 3'd0 || bus.error !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: num=%0d done=%b busy=%b symCount=%0d error=%b, required all 0",
               bus.num, bus.done, bus.busy, bus.symCount, bus.error);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = i + 1;
    rearm();
    send_full("basic");
    n_cmp++;
    if (bus.num !== 32'h0001E240) begin
      n_err++;
      $display("FAIL basic_hex: num=%h, required 0001e240", bus.num);
    end
  endtask

  task automatic test_done_hold();
    send_sym(5, MIN_HIGH + 6);
    tick(8);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.num !== 32'(last_num) || bus.symCount !== 3'(NUM_SYMBOLS)) begin
      n_err++;
      $display("FAIL done_hold: done=%b num=%0d symCount=%0d, required 1/%0d/%0d",
               bus.done, bus.num, bus.symCount, last_num, NUM_SYMBOLS);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = i + 1;
    rearm();
    send_partial(2, "glitch_pre");
    for (int g = 0; g < 3; g++) begin
      send_sym(7, 1 + int'($urandom_range(MIN_HIGH - 2, 0)));
      tick(5);
      n_cmp++;
      if (bus.symCount !== 3'd2) begin
        n_err++;
        $display("FAIL glitch_count: symCount=%0d, required 2", bus.symCount);
      end
    end
    for (int i = 2; i < NUM_SYMBOLS; i++) dig[i - 2] = dig[i];
    for (int i = 0; i < 2; i++) dig[NUM_SYMBOLS - 4 + 2 + i] = 0;
    // remaining four digits 3,4,5,6 sent; full result still 123456
    for (int i = 0; i < NUM_SYMBOLS - 2; i++) dig[i] = i + 3;
    for (int i = 0; i < NUM_SYMBOLS - 3; i++) begin
      send_sym(dig[i], MIN_HIGH + 4);
      tick(5);
    end
    send_sym(dig[NUM_SYMBOLS - 3], MIN_HIGH + 4);
    tick(4);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.num !== 32'd123456) begin
      n_err++;
      $display("FAIL glitch_result: done=%b num=%0d, required 1/123456", bus.done, bus.num);
    end
    last_num = 123456;
  endtask

  task automatic test_abort();
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = $urandom_range(7, 0);
    rearm();
    send_partial(3, "abort_pre");
    bus.enabled = 1'b0;
    tick(1);
    n_cmp++;
    if (bus.symCount !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.num !== 32'(last_num)) begin
      n_err++;
      $display("FAIL abort_clear: symCount=%0d busy=%b done=%b num=%0d, required 0/0/0/%0d",
               bus.symCount, bus.busy, bus.done, bus.num, last_num);
    end
    bus.enabled = 1'b1;
    tick(2);
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = 7 - i;
    send_full("abort_frame");
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = 7;
    rearm();
    send_full("max");
    n_cmp++;
    if (bus.num !== 32'h000BDE31) begin
      n_err++;
      $display("FAIL max_hex: num=%h, required 000bde31", bus.num);
    end
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = (i == NUM_SYMBOLS - 1) ? 1 : 0;
    rearm();
    send_full("one");
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = $urandom_range(7, 0);
      rearm();
      send_full("random");
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = $urandom_range(7, 0);
    rearm();
    send_partial(3, "timeout_pre");
    tick(TIMEOUT - 30);
    n_cmp++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_early: error=%b busy=%b, required 0/1", bus.error, bus.busy);
    end
    tick(50);
`ifdef MULTIRECEIVE_TIMEOUT_EN
    n_cmp++;
    if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.symCount !== 3'd3) begin
      n_err++;
      $display("FAIL timeout_error: error=%b done=%b busy=%b symCount=%0d, required 1/0/0/3",
               bus.error, bus.done, bus.busy, bus.symCount);
    end
`else
    n_cmp++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1 || bus.symCount !== 3'd3) begin
      n_err++;
      $display("FAIL timeout_stall: error=%b busy=%b symCount=%0d, required 0/1/3",
               bus.error, bus.busy, bus.symCount);
    end
`endif
    bus.enabled = 1'b0;
    tick(1);
    n_cmp++;
    if (bus.error !== 1'b0 || bus.symCount !== 3'd0) begin
      n_err++;
      $display("FAIL timeout_clear: error=%b symCount=%0d, required 0/0", bus.error, bus.symCount);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = $urandom_range(7, 0);
    rearm();
    send_partial(4, "rmid_pre");
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.num !== 32'd0 || bus.symCount !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: num=%0d symCount=%0d busy=%b done=%b, required 0/0/0/0",
               bus.num, bus.symCount, bus.busy, bus.done);
    end
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < NUM_SYMBOLS; i++) dig[i] = $urandom_range(7, 0);
    rearm();
    send_full("rmid_frame");
  endtask

  initial begin
    bus.enabled   = 1'b0;
    bus.in0       = 1'b0;
    bus.in1       = 1'b0;
    bus.in2       = 1'b0;
    bus.controlIn = 1'b0;
    test_reset();
    test_basic();
    test_done_hold();
    test_glitch();
    test_abort();
    test_boundary();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multireceive.md
Name: multireceive

Overview:
- Receiving end of the multi-digit symbol link driven by the multi-digit sender on a peer board.
- Accepts 3-bit symbols on in0..in2, each qualified by a controlIn high pulse, and collects NUM_SYMBOLS of them, most significant digit first.
- Rebuilds the decimal value and presents it as a 32-bit number with a done flag, for the keylock compare logic.

Parameters:
- MIN_HIGH, 1000: cycles synchronized controlIn must stay high before a symbol is accepted (glitch filter).
- NUM_SYMBOLS, 6: digits per frame.
- TIMEOUT, 3600000: maximum idle cycles between symbols once a frame has started (0.3 s at 12 MHz).

Ports:
- hwclk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enabled  input  1  high = receive; low = abort/clear and rearm.
- in0  input  1  symbol bit 0 (asynchronous).
- in1  input  1  symbol bit 1 (asynchronous).
- in2  input  1  symbol bit 2 (asynchronous).
- controlIn  input  1  symbol strobe from sender (asynchronous).
- num  output  32  reconstructed value, zero-extended.
- done  output  1  frame complete, num valid.
- busy  output  1  frame in progress (at least one symbol accepted, not done).
- symCount  output  3  symbols accepted in current frame.
- error  output  1  frame aborted by timeout (feature-dependent).

Behaviour:
- Clock/reset: single clock hwclk; reset is asynchronous and active-high. Reset clears all state: num=0, done=0, busy=0, symCount=0, error=0, state IDLE.
- Synchronizers: in0..in2 and controlIn each pass through 2-FF synchronizers. All logic below uses the synchronized versions (ctl_s, sym_s[2:0]).
- enabled low (any state, including mid-frame): next cycle state=IDLE, acc=0, symCount=0, done=0, busy=0, error=0. num holds its last completed value.
- States:
  - IDLE: enabled high -> WAIT_HIGH.
  - WAIT_HIGH: ctl_s=1 -> FILTER with hcnt=1.
  - FILTER:
    - ctl_s=0 before hcnt reaches MIN_HIGH: glitch -> WAIT_HIGH; no symbol, symCount unchanged.
    - hcnt==MIN_HIGH with ctl_s=1: sample sym_s in that cycle; acc = acc*10 + sym_s; symCount+1; -> WAIT_LOW.
  - WAIT_LOW: ctl_s=0 -> COMPLETE if symCount==NUM_SYMBOLS, else WAIT_HIGH.
  - COMPLETE: num=acc (one cycle), done=1, busy=0. Stays here until enabled falls; further strobes are ignored.
  - ERROR: error=1, done=0, busy=0. Stays here until enabled falls.
- Arithmetic:
  - acc is 20 bits; acc*10 is computed as (acc<<3)+(acc<<1). Symbols 0..7 are accepted unchecked; maximum value is 777777.
  - num = {12'b0, acc}.
- Latency: done rises 4 hwclk cycles after controlIn falls on the last symbol (2 synchronizer + WAIT_LOW + COMPLETE registration).
- busy = (symCount>0) and state not in {COMPLETE, ERROR}.
- Simultaneous events: enabled low has priority over every transition. reset has priority over everything.

Optional Feature:
- Macro: MULTIRECEIVE_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit gap counter runs in WAIT_HIGH while symCount>0, and in WAIT_LOW.
  - It clears on every state change.
  - When it exceeds TIMEOUT: state -> ERROR, error=1, acc/symCount frozen, done never asserts for that frame.
- Without the macro: no gap counter; error is tied 0; a stalled frame waits indefinitely until enabled falls.

Test Plan:
- Frame 1,2,3,4,5,6; each strobe high 2000 cycles, gaps 2000 -> num=123456 (0x0001E240), done=1 four cycles after last controlIn fall, symCount=6, error=0.
- Within a frame, controlIn high for 10 cycles before digit 3 -> glitch ignored, symCount unchanged; frame still yields 123456.
- Three digits sent, enabled dropped for 1 cycle, then frame 7,6,5,4,3,2 -> symCount returns to 0, then num=765432, done=1.
- Frame 7,7,7,7,7,7 -> num=777777 (0x000BDE31); digits 0,0,0,0,0,1 -> num=1.
- MULTIRECEIVE_TIMEOUT_EN: 3 digits sent, then silence for TIMEOUT+2 cycles -> error=1, done=0, busy=0. Dropping enabled clears error.
- reset pulsed mid-frame after 4 digits -> num=0, symCount=0, busy=0 immediately (asynchronously); next full frame decodes correctly.
